// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MULTU/HI-LO unit
package mips_pkg;

   localparam int MULT_W = 32;
   localparam int MULT_CNT_W = $clog2(MULT_W + 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mult_state_t;

endpackage

// File: rtl/multu_step.sv
// multu_step: one combinational shift-add iteration of the unsigned multiplier
module multu_step
   import mips_pkg::*;
#(
   parameter int WIDTH = MULT_W
) (
   input  logic [2*WIDTH-1:0] prod,
   input  logic [WIDTH-1:0]   mcand,
   output logic [2*WIDTH-1:0] prod_next
);

   logic [WIDTH:0] upper;

   // add the multiplicand into the upper half when the current multiplier bit is set,
   // keeping the carry so that the full 2*WIDTH product stays exact
   always_comb begin
      upper     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      prod_next = {upper, prod[WIDTH-1:1]};
   end

endmodule

// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: iterative unsigned MULTU with HI/LO registers and EX-stage stall control
module multu_hilo_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = MULT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mult_enable,
   input  logic             sf2reg,
   input  logic             sfmux_high,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sf_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   mult_state_t        state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [2*WIDTH-1:0] prod_nxt;
   logic               done_q, done_d;

   multu_step #(.WIDTH(WIDTH)) u_step (
      .prod      (prod_q),
      .mcand     (mcand_q),
      .prod_next (prod_nxt)
   );

   // accept a start in IDLE; in BUSY advance one step and commit HI/LO on the final one
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (mult_enable) begin
            state_d = BUSY;
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = CW'(WIDTH);
         end
      end else begin
         prod_d = prod_nxt;
         cnt_d  = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            hi_d    = prod_nxt[2*WIDTH-1:WIDTH];
            lo_d    = prod_nxt[WIDTH-1:0];
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end
   end

   // state registers; reset discards any product in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   // outputs: stall only when a request meets a pending product
   always_comb begin
      busy    = (state_q == BUSY);
      stall   = busy & (mult_enable | sf2reg);
      sf_data = sfmux_high ? hi_q : lo_q;
      hi      = hi_q;
      lo      = lo_q;
      done    = done_q;
   end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb_multu_hilo_unit: randomized and directed checks against a countdown reference model
module tb_multu_hilo_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mult_enable = 1'b0;
   logic        sf2reg = 1'b0;
   logic        sfmux_high = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] sf_data, hi, lo;
   logic        busy, stall, done;

   int n_chk = 0;
   int n_fail = 0;

   int          m_left = 0;
   logic [63:0] m_pend = '0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic        m_done = 1'b0;

   multu_hilo_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mult_enable (mult_enable),
      .sf2reg      (sf2reg),
      .sfmux_high  (sfmux_high),
      .a           (a),
      .b           (b),
      .sf_data     (sf_data),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .stall       (stall),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_left = 0;
      m_pend = '0;
      m_hi   = '0;
      m_lo   = '0;
      m_done = 1'b0;
   endtask

   // drive one cycle of inputs, check every output against the model, then clock once
   task automatic step(input logic me, input logic sf, input logic hs,
                       input logic [31:0] av, input logic [31:0] bv);
      mult_enable = me;
      sf2reg      = sf;
      sfmux_high  = hs;
      a           = av;
      b           = bv;
      #1;
      check("busy", busy, m_left != 0);
      check("stall", stall, (m_left != 0) && (me || sf));
      check("done", done, m_done);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("sf_data", sf_data, hs ? m_hi : m_lo);
      @(posedge clk);
      #1;
      m_done = 1'b0;
      if (m_left != 0) begin
         m_left--;
         if (m_left == 0) begin
            m_hi   = m_pend[63:32];
            m_lo   = m_pend[31:0];
            m_done = 1'b1;
         end
      end else if (me) begin
         m_pend = {32'b0, av} * {32'b0, bv};
         m_left = 32;
      end
   endtask

   task automatic run(input logic [31:0] av, input logic [31:0] bv);
      int guard;
      step(1'b1, 1'b0, 1'b0, av, bv);
      guard = 0;
      while (m_left != 0 && guard < 40) begin
         step(1'b0, 1'b0, 1'b0, '0, '0);
         guard++;
      end
      check("run_len", guard, 32);
      step(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      int dn;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;

      run(32'd3, 32'd5);
      check("t1_hi", hi, 32'h0);
      check("t1_lo", lo, 32'hF);

      run(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("t2_hi", hi, 32'hFFFF_FFFE);
      check("t2_lo", lo, 32'h0000_0001);

      run(32'h8000_0000, 32'd2);
      check("t3_hi", hi, 32'h1);
      check("t3_lo", lo, 32'h0);

      // MFHI issued mid-multiply stalls until the new product is in
      step(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (4) step(1'b0, 1'b0, 1'b0, '0, '0);
      check("t4_old_hi", hi, 32'h1);
      while (m_left != 0) step(1'b0, 1'b1, 1'b1, '0, '0);
      #1;
      check("t4_stall_off", stall, 0);
      check("t4_new_hi", sf_data, 32'h0B00_EA4E);
      step(1'b0, 1'b1, 1'b1, '0, '0);

      run(32'd0, 32'h1234);
      check("t3b_hi", hi, 32'h0);
      check("t3b_lo", lo, 32'h0);

      // a second MULTU held in EX is taken on the first idle edge
      step(1'b1, 1'b0, 1'b0, 32'd7, 32'd9);
      while (m_left != 0) step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1000);
      check("t5_first_lo", lo, 32'd63);
      step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1000);
      check("t5_accepted", busy, 1);
      while (m_left != 0) step(1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b0, 1'b0, '0, '0);
      check("t5_hi", hi, 32'h0000_0DEA);
      check("t5_lo", lo, 32'hDBEE_F000);

      // reset in the middle of a multiply
      step(1'b1, 1'b0, 1'b0, 32'hABCD_0123, 32'h4567_89AB);
      repeat (9) step(1'b0, 1'b0, 1'b0, '0, '0);
      mult_enable = 1'b1;
      rst_n = 1'b0;
      #1;
      check("t6_hi", hi, 0);
      check("t6_lo", lo, 0);
      check("t6_busy", busy, 0);
      check("t6_stall", stall, 0);
      check("t6_done", done, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run(32'd100, 32'd200);
      check("t6_after", lo, 32'd20000);

      // randomized traffic, counting done pulses against completed products
      dn = 0;
      repeat (1500) begin
         step($urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
              1'($urandom_range(0, 1)), $urandom, $urandom);
         if (m_done) dn++;
      end
      while (m_left != 0) step(1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b0, 1'b1, '0, '0);
      check("rand_any_done", dn > 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
